pipeline_control_unit: RTL and testbench

Stall/flush responder for the 5-stage core. It consumes the load-use `stall` produced in ID, EX branch redirects, and instruction and data memory ready handshakes. From these it drives per-stage write enables and bubble (flush) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It holds a small FSM that discards a wrong-path fetch still in flight when a redirect occurs, and keeps stall/flush performance counters.

---
 rtl/pipeline_control_unit_if.sv | 53 +++++
 rtl/pipeline_control_unit.sv | 131 +++++++++++++
 tb/tb_pipeline_control_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_if.sv
// ---------------------------------------------------------------------------
// pipeline_control_unit_if
// Bundles the hazard/handshake inputs and the per-stage control outputs of
// the pipeline control unit so that they travel as a single port.
//
// Signals:
//   load_use_stall, branch_taken_ex, imem_ready,
//   dmem_req_mem, dmem_ready_mem          - hazard and memory handshake inputs
//   pc_en, if_id_en, id_ex_en,
//   ex_mem_en, mem_wb_en                  - pipeline register write enables
//   if_id_flush, id_ex_flush, mem_wb_flush - bubble insertion controls
//   discard_o                             - unit is dropping a wrong-path fetch
//   stall_cycles, flush_count             - performance counters
//
// Modports:
//   master - the core side that produces hazards and consumes controls
//   slave  - the control unit itself
// ---------------------------------------------------------------------------
interface pipeline_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             load_use_stall;
  logic             branch_taken_ex;
  logic             imem_ready;
  logic             dmem_req_mem;
  logic             dmem_ready_mem;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             discard_o;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output load_use_stall, branch_taken_ex, imem_ready, dmem_req_mem, dmem_ready_mem,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  discard_o, stall_cycles, flush_count
  );

  modport slave (
    input  load_use_stall, branch_taken_ex, imem_ready, dmem_req_mem, dmem_ready_mem,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output discard_o, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// pipeline_control_unit
// Stall/flush responder for the 5-stage core. Turns the ID load-use hazard,
// EX branch redirects and the instruction/data memory handshakes into
// per-stage write enables and bubble controls. A two-state FSM remembers
// that a wrong-path fetch is still in flight after a redirect so that its
// word is thrown away instead of entering IF/ID. Two counters track stall
// cycles and accepted redirects.
//
// Ports:
//   clk  - core clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - pipeline_control_unit_if.slave, hazards in / controls out
// ---------------------------------------------------------------------------
module pipeline_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  pipeline_control_unit_if.slave         bus
);

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic dmem_wait;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic redirect;

  assign dmem_wait = bus.dmem_req_mem & ~bus.dmem_ready_mem;

  // Priority-ordered hazard resolution. A data-memory wait outranks the
  // branch because EX is frozen and cannot hand its redirect over yet; the
  // branch is simply seen again once the freeze lifts.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    redirect     = 1'b0;
    state_d      = state_q;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = RUN;
    end else if (dmem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (bus.branch_taken_ex) begin
      // An unfinished fetch belongs to the old path and must be dropped
      // when it eventually returns.
      pc_en       = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect    = 1'b1;
      state_d     = bus.imem_ready ? RUN : DISCARD;
    end else if (bus.load_use_stall) begin
      // IF/ID is held, so a wrong-path word arriving now is never written
      // and the discard is complete.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      if (state_q == DISCARD && bus.imem_ready) begin
        state_d = RUN;
      end
    end else if (state_q == DISCARD) begin
      // PC already holds the branch target; keep it while the stale word
      // drains.
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      if (bus.imem_ready) begin
        state_d = RUN;
      end
    end else if (!bus.imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Counters wrap freely; reset cycles never count as stalls.
  always_comb begin
    stall_cycles_d = stall_cycles_q + CNT_W'(!pc_en);
    flush_count_d  = flush_count_q + CNT_W'(redirect);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.discard_o    = (state_q == DISCARD);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control_unit
// Self-checking bench for pipeline_control_unit. A behavioural model keeps
// the discard flag and both counters; expected controls come from picking
// which hazard rule applies and looking up that rule's control pattern.
// ---------------------------------------------------------------------------
module tb_pipeline_control_unit;

  logic clk = 1'b0;
  logic rst;

  pipeline_control_unit_if #(.CNT_W(32)) bus ();

  pipeline_control_unit #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          model_discard;
  logic [31:0] model_stalls;
  logic [31:0] model_flushes;

  // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb enables, then
  // if_id, id_ex, mem_wb flushes.
  function automatic logic [7:0] ctrl_now();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
  endfunction

  // Which hazard rule governs the current inputs (1..7, highest priority first)
  function automatic int rule_now();
    if (rst) return 1;
    if (bus.dmem_req_mem && !bus.dmem_ready_mem) return 2;
    if (bus.branch_taken_ex) return 3;
    if (bus.load_use_stall) return 4;
    if (model_discard) return 5;
    if (!bus.imem_ready) return 6;
    return 7;
  endfunction

  function automatic logic [7:0] exp_ctrl();
    case (rule_now())
      1:       return 8'b00000_111;
      2:       return 8'b00001_001;
      3:       return 8'b11111_110;
      4:       return 8'b00111_010;
      5, 6:    return 8'b01111_100;
      default: return 8'b11111_000;
    endcase
  endfunction

  task automatic drive(input bit r, input bit lu, input bit br, input bit im,
                       input bit dq, input bit dr);
    rst                 = r;
    bus.load_use_stall  = lu;
    bus.branch_taken_ex = br;
    bus.imem_ready      = im;
    bus.dmem_req_mem    = dq;
    bus.dmem_ready_mem  = dr;
  endtask

  // Clock one edge and update the model from the inputs of that cycle.
  task automatic advance();
    int  r;
    bit  stalled;
    @(posedge clk);
    r       = rule_now();
    stalled = (exp_ctrl() >> 7) == 8'd0;
    if (r == 1) begin
      model_discard = 1'b0;
      model_stalls  = '0;
      model_flushes = '0;
    end else begin
      if (stalled) model_stalls = model_stalls + 1;
      if (r == 3) begin
        model_flushes = model_flushes + 1;
        model_discard = !bus.imem_ready;
      end else if ((r == 4 || r == 5) && bus.imem_ready) begin
        model_discard = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 0, 0);
    #1;
    total++;
    if (ctrl_now() !== 8'b00000_111) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got=%b want=%b", ctrl_now(), 8'b00000_111);
    end
    advance();
    advance();
    total++;
    if (bus.discard_o !== 1'b0 || bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%b/%0d/%0d want=0/0/0",
               bus.discard_o, bus.stall_cycles, bus.flush_count);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      #1;
      total++;
      if (ctrl_now() !== 8'b11111_000) begin
        bad++;
        $display("[TB] FAIL idle_ctrl cyc=%0d got=%b want=%b", i, ctrl_now(), 8'b11111_000);
      end
      advance();
    end
    total++;
    if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL idle_counters got=%0d/%0d want=0/0", bus.stall_cycles, bus.flush_count);
    end
  endtask

  task automatic test_load_use();
    drive(0, 1, 0, 1, 0, 0);
    #1;
    total++;
    if (ctrl_now() !== 8'b00111_010) begin
      bad++;
      $display("[TB] FAIL load_use_ctrl got=%b want=%b", ctrl_now(), 8'b00111_010);
    end
    advance();
    drive(0, 0, 0, 1, 0, 0);
    #1;
    total++;
    if (bus.stall_cycles !== 32'd1) begin
      bad++;
      $display("[TB] FAIL load_use_stalls got=%0d want=1", bus.stall_cycles);
    end
    advance();
  endtask

  task automatic test_redirect_discard();
    logic [31:0] fc0;
    int          discard_seen;
    fc0          = bus.flush_count;
    discard_seen = 0;
    drive(0, 0, 1, 0, 0, 0);
    #1;
    total++;
    if (ctrl_now() !== 8'b11111_110) begin
      bad++;
      $display("[TB] FAIL redirect_branch got=%b want=%b", ctrl_now(), 8'b11111_110);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, (i == 2), 0, 0);
      #1;
      if (bus.discard_o === 1'b1) discard_seen++;
      total++;
      if (ctrl_now() !== 8'b01111_100) begin
        bad++;
        $display("[TB] FAIL redirect_discard cyc=%0d got=%b want=%b", i, ctrl_now(), 8'b01111_100);
      end
      advance();
    end
    total++;
    if (discard_seen != 3 || bus.discard_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL redirect_discard_len got=%0d/%b want=3/0", discard_seen, bus.discard_o);
    end
    total++;
    if (bus.flush_count !== fc0 + 32'd1) begin
      bad++;
      $display("[TB] FAIL redirect_count got=%0d want=%0d", bus.flush_count, fc0 + 32'd1);
    end
  endtask

  task automatic test_dmem_branch();
    logic [31:0] fc0;
    fc0 = bus.flush_count;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 0);
      #1;
      total++;
      if (ctrl_now() !== 8'b00001_001) begin
        bad++;
        $display("[TB] FAIL dmem_freeze cyc=%0d got=%b want=%b", i, ctrl_now(), 8'b00001_001);
      end
      advance();
      total++;
      if (bus.flush_count !== fc0) begin
        bad++;
        $display("[TB] FAIL dmem_no_redirect cyc=%0d got=%0d want=%0d", i, bus.flush_count, fc0);
      end
    end
    drive(0, 0, 1, 1, 1, 1);
    #1;
    total++;
    if (ctrl_now() !== 8'b11111_110) begin
      bad++;
      $display("[TB] FAIL dmem_release got=%b want=%b", ctrl_now(), 8'b11111_110);
    end
    advance();
    total++;
    if (bus.flush_count !== fc0 + 32'd1 || bus.discard_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dmem_release_count got=%0d/%b want=%0d/0",
               bus.flush_count, bus.discard_o, fc0 + 32'd1);
    end
  endtask

  task automatic test_branch_vs_load_use();
    drive(0, 1, 1, 1, 0, 0);
    #1;
    total++;
    if (ctrl_now() !== 8'b11111_110) begin
      bad++;
      $display("[TB] FAIL branch_wins got=%b want=%b", ctrl_now(), 8'b11111_110);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(39) == 0), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
            ($urandom_range(2) != 0), ($urandom_range(3) == 0), ($urandom_range(1) == 0));
      #1;
      total++;
      if (ctrl_now() !== exp_ctrl()) begin
        bad++;
        $display("[TB] FAIL random_ctrl cyc=%0d got=%b want=%b", i, ctrl_now(), exp_ctrl());
      end
      advance();
      total++;
      if (bus.discard_o !== model_discard || bus.stall_cycles !== model_stalls ||
          bus.flush_count !== model_flushes) begin
        bad++;
        $display("[TB] FAIL random_state cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 bus.discard_o, bus.stall_cycles, bus.flush_count,
                 model_discard, model_stalls, model_flushes);
      end
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 1, 0, 0);
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    model_stalls = 32'hFFFF_FFFF;
    #1;
    total++;
    if (bus.stall_cycles !== 32'hFFFF_FFFF) begin
      bad++;
      $display("[TB] FAIL wrap_preload got=%h want=ffffffff", bus.stall_cycles);
    end
    advance();
    total++;
    if (bus.stall_cycles !== 32'd0) begin
      bad++;
      $display("[TB] FAIL wrap_counter got=%h want=00000000", bus.stall_cycles);
    end
  endtask

  task automatic test_reset_in_discard();
    drive(0, 0, 1, 0, 0, 0);
    advance();
    total++;
    if (bus.discard_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL enter_discard got=%b want=1", bus.discard_o);
    end
    drive(1, 0, 0, 0, 0, 0);
    advance();
    total++;
    if (bus.discard_o !== 1'b0 || bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_in_discard got=%b/%0d/%0d want=0/0/0",
               bus.discard_o, bus.stall_cycles, bus.flush_count);
    end
    drive(0, 0, 0, 1, 0, 0);
    advance();
  endtask

  initial begin
    model_discard = 1'b0;
    model_stalls  = '0;
    model_flushes = '0;
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk);
    test_reset();
    test_idle();
    test_load_use();
    test_redirect_discard();
    test_dmem_branch();
    test_branch_vs_load_use();
    test_random();
    test_wrap();
    test_reset_in_discard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
